// File: rtl/dds_param_ctrl_if.sv
// dds_param_ctrl_if: key pulses towards the controller, DDS parameter words back out
interface dds_param_ctrl_if #(
  parameter int FW_WIDTH = 32,
  parameter int PW_WIDTH = 12
);
  logic [3:0]          key_flag;
  logic [3:0]          wave_sel;
  logic [FW_WIDTH-1:0] freq_word;
  logic [PW_WIDTH-1:0] phase_word;
  logic                sweep_active;
  logic                param_upd;
  modport master (output key_flag, input wave_sel, freq_word, phase_word, sweep_active, param_upd);
  modport slave (input key_flag, output wave_sel, freq_word, phase_word, sweep_active, param_upd);
endinterface

// File: rtl/dds_param_ctrl.sv
// dds_param_ctrl: key-driven DDS wave/frequency/phase sequencer; DDS_SWEEP_EN swaps key3 phase stepping for a triangular frequency sweep
module dds_param_ctrl #(
  parameter int FW_WIDTH  = 32,
  parameter int FW_INIT   = 85_899,
  parameter int FW_MIN    = 85_899,
  parameter int FW_MAX    = 858_993,
  parameter int FW_STEP   = 85_899,
  parameter int DWELL_MAX = 5_000_000,
  parameter int PW_WIDTH  = 12,
  parameter int PW_STEP   = 1024
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  dds_param_ctrl_if.slave bus
);
  localparam int W1 = FW_WIDTH + 1;
  localparam logic [W1-1:0] MAX1 = W1'(FW_MAX);
  localparam logic [W1-1:0] LIM1 = W1'(FW_MIN) + W1'(FW_STEP);
  localparam logic [FW_WIDTH-1:0] FMIN  = FW_WIDTH'(FW_MIN);
  localparam logic [FW_WIDTH-1:0] FMAX  = FW_WIDTH'(FW_MAX);
  localparam logic [FW_WIDTH-1:0] FSTEP = FW_WIDTH'(FW_STEP);
  localparam logic [FW_WIDTH-1:0] FINIT = FW_WIDTH'(FW_INIT);
  if (DWELL_MAX < 1 || PW_WIDTH < 1 || PW_STEP < 0 || FW_MIN > FW_MAX) begin : g_bad_cfg
    $error("dds_param_ctrl: inconsistent parameters");
  end
  logic [3:0] kf, ws;
  logic k0, k1, k2, k3, upd;
  logic [FW_WIDTH-1:0] fw, fw_up, fw_dn, fw_nx;
  logic [W1-1:0] up;
  assign kf = bus.key_flag;
  assign k3 = kf[3];
  assign k2 = kf[2] & ~kf[3];
  assign k1 = kf[1] & ~|kf[3:2];
  assign k0 = kf[0] & ~|kf[3:1];
  // fw_up/fw_dn already give the saturated value at the boundaries, so the sweep reuses them
  assign up = {1'b0, fw} + W1'(FW_STEP);
  assign fw_up = up > MAX1 ? FMAX : up[FW_WIDTH-1:0];
  assign fw_dn = {1'b0, fw} < LIM1 ? FMIN : fw - FSTEP;
  assign bus.wave_sel = ws;
  assign bus.freq_word = fw;
  assign bus.param_upd = upd;
`ifdef DDS_SWEEP_EN
  typedef enum logic [1:0] {MANUAL, SWEEP_UP, SWEEP_DOWN} state_t;
  localparam int CW = DWELL_MAX > 1 ? $clog2(DWELL_MAX) : 1;
  localparam logic [CW-1:0] CLAST = CW'(DWELL_MAX - 1);
  state_t st;
  logic [CW-1:0] cnt;
  logic act, step;
  assign step = st != MANUAL && cnt == CLAST && !k3;
  always_comb fw_nx = st == MANUAL ? (k1 ? fw_up : k2 ? fw_dn : fw) : step ? (st == SWEEP_UP ? fw_up : fw_dn) : fw;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      st  <= MANUAL;
      cnt <= '0;
      act <= 1'b0;
      ws  <= 4'b0001;
      fw  <= FINIT;
      upd <= 1'b0;
    end else begin
      ws  <= k0 ? {ws[2:0], ws[3]} : ws;
      fw  <= fw_nx;
      upd <= k0 || fw_nx != fw;
      cnt <= (k3 || st == MANUAL || cnt == CLAST) ? '0 : cnt + CW'(1);
      if (k3) begin
        st  <= st == MANUAL ? SWEEP_UP : MANUAL;
        act <= st == MANUAL;
      end else if (step && st == SWEEP_UP && up >= MAX1) st <= SWEEP_DOWN;
      else if (step && st == SWEEP_DOWN && {1'b0, fw} <= LIM1) st <= SWEEP_UP;
    end
  assign bus.phase_word = '0;
  assign bus.sweep_active = act;
`else
  logic [PW_WIDTH-1:0] pw;
  always_comb fw_nx = k1 ? fw_up : k2 ? fw_dn : fw;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      ws  <= 4'b0001;
      fw  <= FINIT;
      pw  <= '0;
      upd <= 1'b0;
    end else begin
      ws  <= k0 ? {ws[2:0], ws[3]} : ws;
      fw  <= fw_nx;
      pw  <= k3 ? pw + PW_WIDTH'(PW_STEP) : pw;
      upd <= k0 || k3 || fw_nx != fw;
    end
  assign bus.phase_word = pw;
  assign bus.sweep_active = 1'b0;
`endif
endmodule

// File: doc/dds_param_ctrl.md
# dds_param_ctrl

Parameter controller for the DDS signal generator. Consumes the single-cycle key pulses from the four `key_filter` debouncers and sequences the DDS configuration:
- waveform select;
- frequency control word;
- phase offset word;
- an optional automatic triangular frequency sweep.

It sits between the key debouncers and the DDS phase accumulator / waveform ROM, and it replaces direct key-to-wave_sel decoding.

## Interface
Parameters:
- FW_WIDTH, 32: frequency word width.
- FW_INIT, 85_899: frequency word after reset (1 kHz at 50 MHz, 32-bit accumulator).
- FW_MIN, 85_899: lower frequency word limit.
- FW_MAX, 858_993: upper frequency word limit.
- FW_STEP, 85_899: frequency increment per key press or per sweep step.
- DWELL_MAX, 5_000_000: sys_clk cycles per sweep step (100 ms).
- PW_WIDTH, 12: phase word width.
- PW_STEP, 1024: phase increment per key3 press (90°), used only without the sweep feature.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key_flag  in  4  debounced one-cycle press pulses, bit n = key n.
- wave_sel  out  4  one-hot waveform select.
- freq_word  out  FW_WIDTH  DDS frequency control word.
- phase_word  out  PW_WIDTH  DDS phase offset word.
- sweep_active  out  1  high while the sweep FSM is not in MANUAL.
- param_upd  out  1  one-cycle strobe, high in the first cycle any of wave_sel, freq_word or phase_word holds a new value.

## Operation
- Reset values: wave_sel=4'b0001, freq_word=FW_INIT, phase_word=0, sweep_active=0, param_upd=0, FSM=MANUAL, dwell counter=0.
- Key priority when several key_flag bits are high in one cycle: key3 > key2 > key1 > key0. Only the winning key acts; the losing pulses are discarded.
- key0: rotate wave_sel left (0001→0010→0100→1000→0001). Honoured in every FSM state.
- key1: freq_word += FW_STEP, saturating at FW_MAX. MANUAL state only; ignored while sweeping.
- key2: freq_word -= FW_STEP, saturating at FW_MIN. MANUAL state only; ignored while sweeping.
- Saturation arithmetic:
  - Up: compute in FW_WIDTH+1 bits; if freq_word + FW_STEP > FW_MAX, load FW_MAX.
  - Down: if freq_word < FW_MIN + FW_STEP, load FW_MIN.
- A key press that leaves a word unchanged (already saturated) does not pulse param_upd.
- Sweep FSM (only with DDS_SWEEP_EN), states MANUAL, SWEEP_UP, SWEEP_DOWN:
  - MANUAL --key3--> SWEEP_UP. Dwell counter cleared on entry.
  - SWEEP_UP / SWEEP_DOWN --key3--> MANUAL. freq_word holds its current value; dwell counter cleared.
  - In a SWEEP state the dwell counter counts 0..DWELL_MAX-1, then wraps to 0. A sweep step occurs on the DWELL_MAX-1 cycle.
  - SWEEP_UP step: if freq_word + FW_STEP >= FW_MAX, load FW_MAX and go to SWEEP_DOWN; otherwise add FW_STEP.
  - SWEEP_DOWN step: if freq_word <= FW_MIN + FW_STEP, load FW_MIN and go to SWEEP_UP; otherwise subtract FW_STEP.
  - A key3 pulse arriving in the same cycle as a sweep step wins: go to MANUAL, no step applied.
- sweep_active = (state != MANUAL), registered.
- Reset mid-sweep returns every output to its reset value immediately (asynchronous reset).

## Timing
- Fully registered outputs, no combinational path from inputs to outputs.
- A key_flag pulse sampled at edge n produces the updated output and param_upd=1 after edge n; param_upd falls after edge n+1.
- Sweep period per step: DWELL_MAX cycles. The first step after entering sweep occurs DWELL_MAX cycles after the key3 edge.
- key_flag is assumed synchronous to sys_clk and at most one cycle wide per press.

## Configuration
- DDS_SWEEP_EN defined: key3 toggles the sweep FSM as described above; phase_word stays 0.
- DDS_SWEEP_EN undefined:
  - No FSM and no dwell counter; sweep_active is tied to 0.
  - key1/key2 are accepted at all times.
  - key3 does phase_word += PW_STEP modulo 2^PW_WIDTH (wraps 3072→0 with defaults) and pulses param_upd.

## Test plan
Bench parameters: FW_MIN=10, FW_MAX=40, FW_STEP=10, FW_INIT=10, DWELL_MAX=4.
- Reset, then four key0 pulses → wave_sel 0010, 0100, 1000, 0001; each change is one cycle after its pulse, with a one-cycle param_upd.
- Five key1 pulses → freq_word 20, 30, 40, 40, 40; param_upd only on the first three. Then key2 ×5 → 30, 20, 10, 10, 10.
- key1 and key0 in the same cycle → freq_word +10, wave_sel unchanged; key0 is dropped.
- DDS_SWEEP_EN, key3 at freq 10 → sweep_active=1. freq_word steps every 4 cycles: 20, 30, 40 (enters SWEEP_DOWN), 30, 20, 10 (enters SWEEP_UP). key1 pulses during the sweep have no effect.
- DDS_SWEEP_EN, key3 on the step cycle → MANUAL, freq unchanged, sweep_active=0. Assert sys_rst_n low mid-sweep → all reset values within the same cycle.
- No DDS_SWEEP_EN, key3 ×5 with PW_STEP=1024 → phase_word 1024, 2048, 3072, 0, 1024; sweep_active stays 0.
